mem_wb_stage: RTL and testbench

//  Memory-access/writeback stage directly downstream of the ALU. Accepts one op per

---
 rtl/mem_wb_stage.sv | 131 +++++++++++++
 tb/tb_mem_wb_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage: takes one op per valid/ready handshake, runs the
// data-memory req/ack transaction for loads/stores, then issues the register-file write.
module mem_wb_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [REG_AW-1:0] wrs_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              wb_en_o,
    output logic [REG_AW-1:0] wb_rs_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              err_o
);

    typedef enum logic [1:0] {IDLE, MEM, WB, ERR} state_t;

    localparam logic [1:0] OP_ALU   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                accept;
    logic                misaligned;
    logic                is_store;
    logic [DATA_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [REG_AW-1:0]   wrs_r;
    logic                wb_en_r;
    logic [REG_AW-1:0]   wb_rs_r;
    logic [DATA_W-1:0]   wb_data_r;

    assign ready_o     = (state == IDLE) && !rst;
    assign accept      = valid_i && ready_o;
    assign misaligned  = (alu_result_i[1:0] != 2'b00);

    assign mem_req_o   = (state == MEM);
    assign mem_we_o    = (state == MEM) && is_store;
    assign mem_addr_o  = addr_r;
    assign mem_wdata_o = wdata_r;
    assign wb_en_o     = wb_en_r;
    assign wb_rs_o     = wb_rs_r;
    assign wb_data_o   = wb_data_r;
    assign err_o       = (state == ERR);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op_i)
                        OP_ALU:           state_nxt = WB;
                        OP_LOAD, OP_STORE: state_nxt = misaligned ? ERR : MEM;
                        default:          state_nxt = IDLE;
                    endcase
                end
            end
            MEM: begin
                // Ack wins over the timeout on the last allowed wait cycle.
                if (mem_ack_i)
                    state_nxt = is_store ? IDLE : WB;
                else if (cnt == CNT_LAST)
                    state_nxt = ERR;
            end
            WB:      state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            is_store  <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= '0;
            wrs_r     <= '0;
            wb_en_r   <= 1'b0;
            wb_rs_r   <= '0;
            wb_data_r <= '0;
        end else begin
            state   <= state_nxt;
            wb_en_r <= 1'b0;

            if (accept) begin
                is_store <= (op_i == OP_STORE);
                addr_r   <= alu_result_i;
                wdata_r  <= rs2_data_i;
                wrs_r    <= wrs_i;
                cnt      <= '0;
                // r0 writes are suppressed entirely so wb_rs/wb_data keep their last value.
                if (op_i == OP_ALU && wrs_i != '0) begin
                    wb_en_r   <= 1'b1;
                    wb_rs_r   <= wrs_i;
                    wb_data_r <= alu_result_i;
                end
            end

            if (state == MEM) begin
                if (mem_ack_i) begin
                    if (!is_store && wrs_r != '0) begin
                        wb_en_r   <= 1'b1;
                        wb_rs_r   <= wrs_r;
                        wb_data_r <= mem_rdata_i;
                    end
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: vector table driven through a small memory responder, with a
// scoreboard of expected writeback/error events plus hand-written cycle-exact sequences.
module tb_mem_wb_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int TO = 6;

    logic          clk;
    logic          rst;
    logic          valid_i;
    logic          ready_o;
    logic [1:0]    op_i;
    logic [DW-1:0] alu_result_i;
    logic [DW-1:0] rs2_data_i;
    logic [AW-1:0] wrs_i;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [DW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i;
    logic [DW-1:0] mem_rdata_i;
    logic          wb_en_o;
    logic [AW-1:0] wb_rs_o;
    logic [DW-1:0] wb_data_o;
    logic          err_o;

    mem_wb_stage #(.DATA_W(DW), .REG_AW(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
        .alu_result_i(alu_result_i), .rs2_data_i(rs2_data_i), .wrs_i(wrs_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .wb_en_o(wb_en_o), .wb_rs_o(wb_rs_o), .wb_data_o(wb_data_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = nothing expected, 1 = writeback, 2 = error pulse
    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] alu;
        logic [DW-1:0] rs2;
        logic [AW-1:0] wrs;
        int            ack_wait;
        logic [DW-1:0] rdata;
        int            kind;
        logic [AW-1:0] exp_rs;
        logic [DW-1:0] exp_data;
        int            exp_req;
    } vec_t;

    typedef struct {
        int            kind;
        logic [AW-1:0] rs;
        logic [DW-1:0] data;
    } ev_t;

    vec_t vecs[14];
    ev_t  sbq[$];
    ev_t  mon_e;
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int kind, input logic [AW-1:0] rs, input logic [DW-1:0] data);
        ev_t e;
        e.kind = kind;
        e.rs   = rs;
        e.data = data;
        sbq.push_back(e);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready_o && n < 50) begin
            tick();
            n++;
        end
        if (!ready_o) check(name, 32'(ready_o), 32'd1);
    endtask

    // Every writeback or error pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && (wb_en_o || err_o)) begin
            if (sbq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_event: wb_en=%0b err=%0b rs=%0d data=0x%08h, none expected",
                         wb_en_o, err_o, wb_rs_o, wb_data_o);
            end else begin
                mon_e = sbq.pop_front();
                check("ev_kind", wb_en_o ? 32'd1 : 32'd2, 32'(mon_e.kind));
                if (mon_e.kind == 1) begin
                    check("ev_wb_rs", 32'(wb_rs_o), 32'(mon_e.rs));
                    check("ev_wb_data", wb_data_o, mon_e.data);
                end
            end
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        int n;
        wait_ready("vec_ready_timeout");
        valid_i      = 1'b1;
        op_i         = v.op;
        alu_result_i = v.alu;
        rs2_data_i   = v.rs2;
        wrs_i        = v.wrs;
        if (v.kind != 0) push_ev(v.kind, v.exp_rs, v.exp_data);
        tick();
        valid_i = 1'b0;
        n = 0;
        while (mem_req_o && n < 64) begin
            check("mem_addr", mem_addr_o, v.alu);
            check("mem_we", 32'(mem_we_o), (v.op == 2'b10) ? 32'd1 : 32'd0);
            if (v.op == 2'b10) check("mem_wdata", mem_wdata_o, v.rs2);
            if (n == v.ack_wait) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = v.rdata;
            end
            tick();
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'hBAD0_0000 | 32'(n);
            n++;
        end
        check($sformatf("vec%0d_req_cycles", idx), 32'(n), 32'(v.exp_req));
        tick();
        wait_ready("vec_drain_timeout");
        check($sformatf("vec%0d_sb_drained", idx), 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //            op     alu            rs2           wrs  wait   rdata          kind rs   data           req
        vecs[0]  = '{2'b00, 32'h0000_00AA, 32'h0,        5'd5,  -1,  32'h0,         1, 5'd5,  32'h0000_00AA, 0};
        vecs[1]  = '{2'b01, 32'h0000_0100, 32'h0,        5'd7,   3,  32'hDEAD_BEEF, 1, 5'd7,  32'hDEAD_BEEF, 4};
        vecs[2]  = '{2'b10, 32'h0000_0204, 32'h1234,     5'd6,   0,  32'h0,         0, 5'd0,  32'h0,         1};
        vecs[3]  = '{2'b01, 32'h0000_0102, 32'h0,        5'd8,  -1,  32'h0,         2, 5'd0,  32'h0,         0};
        vecs[4]  = '{2'b01, 32'h0000_0300, 32'h0,        5'd3,  -1,  32'h0,         2, 5'd0,  32'h0,         TO};
        vecs[5]  = '{2'b00, 32'h0000_0055, 32'h0,        5'd0,  -1,  32'h0,         0, 5'd0,  32'h0,         0};
        vecs[6]  = '{2'b11, 32'h0000_0010, 32'h0,        5'd4,  -1,  32'h0,         0, 5'd0,  32'h0,         0};
        vecs[7]  = '{2'b10, 32'h0000_0008, 32'hA5A5_5A5A, 5'd2,  2,  32'h0,         0, 5'd0,  32'h0,         3};
        vecs[8]  = '{2'b10, 32'h0000_0201, 32'h1,        5'd2,  -1,  32'h0,         2, 5'd0,  32'h0,         0};
        vecs[9]  = '{2'b01, 32'h0000_0040, 32'h0,        5'd31,  0,  32'hCAFE_F00D, 1, 5'd31, 32'hCAFE_F00D, 1};
        vecs[10] = '{2'b01, 32'h0000_0044, 32'h0,        5'd0,   1,  32'h1111_2222, 0, 5'd0,  32'h0,         2};
        vecs[11] = '{2'b00, 32'hFFFF_FFFF, 32'h0,        5'd1,  -1,  32'h0,         1, 5'd1,  32'hFFFF_FFFF, 0};
        vecs[12] = '{2'b01, 32'h0000_0048, 32'h0,        5'd9, TO-1, 32'h0BAD_CAFE, 1, 5'd9,  32'h0BAD_CAFE, TO};
        vecs[13] = '{2'b00, 32'h0000_0077, 32'h0,        5'd0,  -1,  32'h0,         0, 5'd0,  32'h0,         0};

        rst = 1'b1; valid_i = 1'b0; op_i = 2'b11; alu_result_i = '0; rs2_data_i = '0;
        wrs_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
        tick();
        tick();
        check("rst_ready_low", 32'(ready_o), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_wb_en", 32'(wb_en_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_wb_data", wb_data_o, 32'd0);
        check("rst_ready_high", 32'(ready_o), 32'd1);

        // ALU-WB: pulse only in the cycle after accept, then values hold.
        valid_i = 1'b1; op_i = 2'b00; alu_result_i = 32'hAA; wrs_i = 5'd5;
        push_ev(1, 5'd5, 32'hAA);
        tick();
        valid_i = 1'b0;
        check("alu_wb_en_n1", 32'(wb_en_o), 32'd1);
        check("alu_wb_rs_n1", 32'(wb_rs_o), 32'd5);
        check("alu_wb_data_n1", wb_data_o, 32'hAA);
        check("alu_ready_n1", 32'(ready_o), 32'd0);
        tick();
        check("alu_wb_en_n2", 32'(wb_en_o), 32'd0);
        check("alu_ready_n2", 32'(ready_o), 32'd1);
        check("alu_hold_data_n2", wb_data_o, 32'hAA);

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);
        check("hold_wb_rs", 32'(wb_rs_o), 32'd9);
        check("hold_wb_data", wb_data_o, 32'h0BAD_CAFE);

        // Misaligned load: no request, error pulse at N+1, ready at N+2.
        wait_ready("mis_ready_timeout");
        valid_i = 1'b1; op_i = 2'b01; alu_result_i = 32'h102; wrs_i = 5'd4;
        push_ev(2, 5'd0, 32'h0);
        tick();
        valid_i = 1'b0;
        check("mis_err_n1", 32'(err_o), 32'd1);
        check("mis_req_n1", 32'(mem_req_o), 32'd0);
        check("mis_we_n1", 32'(mem_we_o), 32'd0);
        check("mis_ready_n1", 32'(ready_o), 32'd0);
        tick();
        check("mis_err_n2", 32'(err_o), 32'd0);
        check("mis_ready_n2", 32'(ready_o), 32'd1);

        // NOP: accepted but the stage never leaves IDLE; a stray ack is ignored.
        valid_i = 1'b1; op_i = 2'b11; alu_result_i = 32'h20; mem_ack_i = 1'b1;
        tick();
        valid_i = 1'b0;
        check("nop_ready_n1", 32'(ready_o), 32'd1);
        check("nop_req_n1", 32'(mem_req_o), 32'd0);
        tick();
        mem_ack_i = 1'b0;
        check("nop_sb_drained", 32'(sbq.size()), 32'd0);

        // Reset in the middle of an unacknowledged load aborts it with no error.
        valid_i = 1'b1; op_i = 2'b01; alu_result_i = 32'h500; wrs_i = 5'd4;
        tick();
        valid_i = 1'b0;
        check("abort_req_n1", 32'(mem_req_o), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("abort_req_in_rst", 32'(mem_req_o), 32'd0);
        check("abort_ready_in_rst", 32'(ready_o), 32'd0);
        check("abort_err_in_rst", 32'(err_o), 32'd0);
        rst = 1'b0;
        tick();
        check("abort_ready_after", 32'(ready_o), 32'd1);
        check("abort_req_after", 32'(mem_req_o), 32'd0);
        check("abort_wb_data_cleared", wb_data_o, 32'd0);
        tick();
        tick();
        check("final_sb_drained", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
